breath_led_sched: RTL and testbench

Four-channel breathing-LED scheduler. One shared PWM timebase and one shared duty ramp drive all four LEDs. A mode FSM, advanced by a debounced key pulse, chooses whether the ramp lights all channels together, rotates it channel-by-channel (chase), or forces the LEDs fully on or off. The block sits between the key debounce logic and the board LED pins and replaces per-LED breath counters.

---
 rtl/breath_led_sched.sv | 95 +++++++++
 tb/tb_breath_led_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/breath_led_sched.sv
// breath_led_sched: four-channel breathing-LED scheduler with one shared PWM timebase and duty ramp.
// Ports:
//   sys_clk    in   system clock (50 MHz)
//   sys_rst_n  in   asynchronous active-low reset
//   key_mode   in   debounced one-cycle pulse, advances IDLE -> BREATH_ALL -> CHASE -> HOLD -> IDLE
//   key_speed  in   debounced one-cycle pulse, advances ramp step 1 -> 2 -> 4 -> 1
//   led_out    out  registered LED drives, active-low
//   mode       out  current mode (0 IDLE, 1 BREATH_ALL, 2 CHASE, 3 HOLD)
module breath_led_sched #(
    parameter logic [5:0] CNT_1US_MAX = 6'd49,
    parameter logic [9:0] CNT_1MS_MAX = 10'd999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_mode,
    input  logic       key_speed,
    output logic [3:0] led_out,
    output logic [1:0] mode
);
    typedef enum logic [1:0] {IDLE, BREATH_ALL, CHASE, HOLD} mode_t;
    mode_t       mode_q, mode_d;
    logic [5:0]  cnt_1us_q, cnt_1us_d;
    logic [9:0]  cnt_1ms_q, cnt_1ms_d;
    logic [2:0]  step_q, step_d;
    logic [9:0]  duty_q, duty_d;
    logic        dir_q, dir_d;
    logic [1:0]  chan_q, chan_d;
    logic [3:0]  led_q, led_d;
    logic        us_end, ms_tick, pwm, ramp_en, cycle_done;
    logic [10:0] sum;
    always_comb begin
        us_end     = cnt_1us_q == CNT_1US_MAX;
        ms_tick    = us_end && cnt_1ms_q == CNT_1MS_MAX;
        pwm        = cnt_1ms_q < duty_q;
        ramp_en    = ms_tick && (mode_q == BREATH_ALL || mode_q == CHASE);
        // 11-bit sum so duty+step near the top of the range cannot wrap
        sum        = {1'b0, duty_q} + {8'b0, step_q};
        cycle_done = ramp_en && dir_q && duty_q <= {7'b0, step_q};
        cnt_1us_d  = us_end ? '0 : cnt_1us_q + 6'd1;
        cnt_1ms_d  = !us_end ? cnt_1ms_q : (cnt_1ms_q == CNT_1MS_MAX ? '0 : cnt_1ms_q + 10'd1);
        step_d     = !key_speed ? step_q : (step_q == 3'd4 ? 3'd1 : step_q << 1);
        mode_d     = key_mode ? mode_t'(mode_q + 2'd1) : mode_q;
    end
    always_comb begin
        duty_d = duty_q;
        dir_d  = dir_q;
        chan_d = chan_q;
        // a mode change restarts the ramp and outranks any coincident ramp step or cycle end
        if (key_mode) begin
            duty_d = '0;
            dir_d  = 1'b0;
            chan_d = '0;
        end else if (ramp_en) begin
            if (!dir_q) begin
                duty_d = sum >= {1'b0, CNT_1MS_MAX} ? CNT_1MS_MAX : sum[9:0];
                dir_d  = sum >= {1'b0, CNT_1MS_MAX};
            end else if (cycle_done) begin
                duty_d = '0;
                dir_d  = 1'b0;
                chan_d = mode_q == CHASE ? chan_q + 2'd1 : chan_q;
            end else begin
                duty_d = duty_q - {7'b0, step_q};
            end
        end
    end
    always_comb begin
        led_d = mode_q == IDLE       ? 4'b1111 :
                mode_q == HOLD       ? 4'b0000 :
                mode_q == BREATH_ALL ? {4{~pwm}} :
                                       ~({3'b0, pwm} << chan_q);
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q    <= IDLE;
            cnt_1us_q <= '0;
            cnt_1ms_q <= '0;
            step_q    <= 3'd1;
            duty_q    <= '0;
            dir_q     <= 1'b0;
            chan_q    <= '0;
            led_q     <= 4'b1111;
        end else begin
            mode_q    <= mode_d;
            cnt_1us_q <= cnt_1us_d;
            cnt_1ms_q <= cnt_1ms_d;
            step_q    <= step_d;
            duty_q    <= duty_d;
            dir_q     <= dir_d;
            chan_q    <= chan_d;
            led_q     <= led_d;
        end
    end
    assign led_out = led_q;
    assign mode    = mode_q;
endmodule

// File: tb/tb_breath_led_sched.sv
// tb_breath_led_sched: scoreboard bench for breath_led_sched with a 20-clock ms_tick.
module tb_breath_led_sched;
    localparam logic [5:0] US = 6'd1;
    localparam logic [9:0] MS = 10'd9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_speed = 1'b0;
    logic [3:0] led_out;
    logic [1:0] mode;

    breath_led_sched #(.CNT_1US_MAX(US), .CNT_1MS_MAX(MS)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .key_mode(key_mode), .key_speed(key_speed),
        .led_out(led_out), .mode(mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] led;
        logic [5:0] us;
        logic [9:0] ms;
        logic [2:0] stp;
        logic [9:0] duty;
        logic       dir;
        logic [1:0] chan;
    } mdl_t;

    mdl_t       m;
    logic [5:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         run_len[$];
    logic [3:0] run_pat[$];

    function automatic mdl_t mdl_next(input mdl_t s, input logic km, input logic ks);
        mdl_t n = s;
        logic lit = int'(s.ms) < int'(s.duty);
        logic tick = (s.us == US) && (s.ms == MS);
        case (s.mode)
            2'd0: n.led = 4'hf;
            2'd1: n.led = lit ? 4'h0 : 4'hf;
            2'd2: n.led = lit ? (4'hf & ~(4'b0001 << s.chan)) : 4'hf;
            default: n.led = 4'h0;
        endcase
        if (km) begin
            n.mode = s.mode + 2'd1;
            n.duty = '0;
            n.dir  = 1'b0;
            n.chan = '0;
        end else if (tick && (s.mode == 2'd1 || s.mode == 2'd2)) begin
            if (!s.dir) begin
                if (int'(s.duty) + int'(s.stp) >= int'(MS)) begin
                    n.duty = MS;
                    n.dir  = 1'b1;
                end else n.duty = 10'(int'(s.duty) + int'(s.stp));
            end else if (int'(s.duty) <= int'(s.stp)) begin
                n.duty = '0;
                n.dir  = 1'b0;
                if (s.mode == 2'd2) n.chan = s.chan + 2'd1;
            end else n.duty = 10'(int'(s.duty) - int'(s.stp));
        end
        if (ks) n.stp = (s.stp == 3'd4) ? 3'd1 : 3'(int'(s.stp) * 2);
        n.us = (s.us == US) ? 6'd0 : s.us + 6'd1;
        if (s.us == US) n.ms = (s.ms == MS) ? 10'd0 : s.ms + 10'd1;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{mode: 2'd0, led: 4'hf, us: 6'd0, ms: 10'd0, stp: 3'd1, duty: 10'd0, dir: 1'b0, chan: 2'd0};
            exp_q.delete();
        end else begin
            m <= mdl_next(m, key_mode, key_speed);
            exp_q.push_back({mdl_next(m, key_mode, key_speed).mode, mdl_next(m, key_mode, key_speed).led});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic km, input logic ks);
        logic [5:0] e;
        key_mode  = km;
        key_speed = ks;
        @(negedge clk);
        key_mode  = 1'b0;
        key_speed = 1'b0;
        cyc++;
        if (exp_q.size() == 0) check("sb_empty", 0, 1);
        else begin
            e = exp_q.pop_front();
            check("sb_led", led_out, e[3:0]);
            check("sb_mode", mode, e[5:4]);
        end
    endtask

    task automatic do_reset();
        key_mode  = 1'b0;
        key_speed = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_led", led_out, 4'hf);
        check("rst_mode", mode, 2'd0);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic collect(input int n, input int budget);
        int cur = 0;
        int k = 0;
        logic [3:0] pat = 4'hf;
        run_len.delete();
        run_pat.delete();
        while (run_len.size() < n && k < budget) begin
            step(1'b0, 1'b0);
            k++;
            if (led_out != 4'hf) begin
                pat = led_out;
                cur++;
            end else if (cur > 0) begin
                run_len.push_back(cur);
                run_pat.push_back(pat);
                cur = 0;
            end
        end
        if (run_len.size() < n) check("run_timeout", run_len.size(), n);
        while (run_len.size() < n) begin
            run_len.push_back(0);
            run_pat.push_back(4'hx);
        end
    endtask

    function automatic int tri_duty(input int i);
        return (i < 9) ? i + 1 : 17 - i;
    endfunction

    initial begin
        logic [3:0] one;
        logic [3:0] pexp;
        int         ch;
        one = 4'b0001;

        do_reset();
        repeat (1000) step(1'b0, 1'b0);
        check("idle_led", led_out, 4'hf);
        check("idle_mode", mode, 2'd0);

        do_reset();
        step(1'b1, 1'b0);
        check("breath_mode", mode, 2'd1);
        collect(18, 500);
        for (int i = 0; i < 17; i++) begin
            check("breath_len", run_len[i], 2 * tri_duty(i));
            check("breath_pat", run_pat[i], 4'h0);
        end
        check("breath_restart", run_len[17], 2);

        do_reset();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        collect(6, 300);
        check("s4_r0", run_len[0], 8);
        check("s4_r1", run_len[1], 16);
        check("s4_r2", run_len[2], 18);
        check("s4_r3", run_len[3], 10);
        check("s4_r4", run_len[4], 2);
        check("s4_r5", run_len[5], 8);

        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("chase_mode", mode, 2'd2);
        collect(69, 1700);
        for (int i = 0; i < 69; i++) begin
            ch   = (i / 17) % 4;
            pexp = 4'hf ^ (one << ch);
            check("chase_pat", run_pat[i], pexp);
            check("chase_len", run_len[i], 2 * tri_duty(i % 17));
        end

        step(1'b1, 1'b1);
        check("hold_mode", mode, 2'd3);
        step(1'b0, 1'b0);
        check("hold_led", led_out, 4'h0);
        step(1'b1, 1'b0);
        check("wrap_mode", mode, 2'd0);
        step(1'b0, 1'b0);
        check("wrap_led", led_out, 4'hf);
        step(1'b1, 1'b0);
        collect(2, 200);
        check("step2_r0", run_len[0], 4);
        check("step2_r1", run_len[1], 8);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_led", led_out, 4'hf);
        check("async_mode", mode, 2'd0);
        check("async_duty", dut.duty_q, 0);

        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        while (cyc < 359) step(1'b0, 1'b0);
        check("pre_duty", dut.duty_q, 1);
        check("pre_dir", dut.dir_q, 1);
        step(1'b1, 1'b0);
        check("coin_mode", mode, 2'd3);
        check("coin_chan", dut.chan_q, 0);
        check("coin_duty", dut.duty_q, 0);
        step(1'b0, 1'b0);
        check("coin_led", led_out, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
